mdu_iter: RTL and testbench

Iterative multiply/divide unit that sits beside the ALU in the execute stage. It takes the same two 32-bit register operands and produces a 64-bit product, or a quotient and remainder, into HI/LO registers after a fixed multi-cycle latency. Control uses a start/busy/done handshake, and the datapath muxes HI/LO into the write-back path.

---
 rtl/mdu_iter_if.sv | 25 ++
 rtl/mdu_iter.sv | 123 ++++++++++++
 tb/tb_mdu_iter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mdu_iter_if.sv
// Request/response bundle between the execute stage and the iterative multiply/divide unit.
interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;
    logic             div_zero_o;
    logic [1:0]       state_o;

    modport master (
        output start_i, op_i, src1_i, src2_i,
        input  busy_o, done_o, hi_o, lo_o, div_zero_o, state_o
    );

    modport slave (
        input  start_i, op_i, src1_i, src2_i,
        output busy_o, done_o, hi_o, lo_o, div_zero_o, state_o
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle,
// with sign fix-up in a final cycle that loads HI/LO.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic      clk_i,
    input  logic      rst_i,
    mdu_iter_if.slave bus
);
    // Handshake: start_i is sampled only while busy_o is low; the accepting edge latches
    // op/operands; done_o is a one-cycle pulse in the first idle cycle, with HI/LO valid.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   src1_q;
    logic               neg_res_q, neg_rem_q, zero_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q, div_zero_q;

    logic [WIDTH-1:0]   mag1_d, mag2_d;
    logic [WIDTH:0]     mul_sum_d, div_shift_d, div_diff_d;
    logic [2*WIDTH-1:0] acc_d, prod_d;
    logic [WIDTH-1:0]   quo_d, rem_d, hi_d, lo_d;

    always_comb begin
        mag1_d = (bus.op_i[0] && bus.src1_i[WIDTH-1]) ? -bus.src1_i : bus.src1_i;
        mag2_d = (bus.op_i[0] && bus.src2_i[WIDTH-1]) ? -bus.src2_i : bus.src2_i;

        // Multiply: low half holds the remaining multiplier bits, consumed LSB first.
        mul_sum_d = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

        // Divide: high half is the partial remainder, low half shifts dividend out / quotient in.
        div_shift_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff_d  = div_shift_d - {1'b0, opnd_q};

        if (!op_q[1]) begin
            acc_d = {mul_sum_d, acc_q[WIDTH-1:1]};
        end else if (!div_diff_d[WIDTH]) begin
            acc_d = {div_diff_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_d = {div_shift_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end

        prod_d = neg_res_q ? -acc_q : acc_q;
        quo_d  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_d  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

        if (!op_q[1]) begin
            hi_d = prod_d[2*WIDTH-1:WIDTH];
            lo_d = prod_d[WIDTH-1:0];
        end else if (zero_q) begin
            hi_d = src1_q;
            lo_d = '1;
        end else begin
            hi_d = rem_d;
            lo_d = quo_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            opnd_q     <= '0;
            acc_q      <= '0;
            src1_q     <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            zero_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        op_q       <= bus.op_i;
                        src1_q     <= bus.src1_i;
                        opnd_q     <= bus.op_i[1] ? mag2_d : mag1_d;
                        acc_q      <= {{WIDTH{1'b0}}, (bus.op_i[1] ? mag1_d : mag2_d)};
                        neg_res_q  <= bus.op_i[0] & (bus.src1_i[WIDTH-1] ^ bus.src2_i[WIDTH-1]);
                        neg_rem_q  <= bus.op_i[0] & bus.src1_i[WIDTH-1];
                        zero_q     <= (bus.src2_i == '0);
                        div_zero_q <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) state_q <= FIX;
                end
                FIX: begin
                    hi_q       <= hi_d;
                    lo_q       <= lo_d;
                    div_zero_q <= op_q[1] & zero_q;
                    done_q     <= 1'b1;
                    cnt_q      <= '0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy_o     = (state_q != IDLE);
    assign bus.done_o     = done_q;
    assign bus.hi_o       = hi_q;
    assign bus.lo_o       = lo_q;
    assign bus.div_zero_o = div_zero_q;
    assign bus.state_o    = state_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: directed vectors, start-while-busy, back-to-back, mid-op reset, random ops.
module tb_mdu_iter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    mdu_iter_if #(.WIDTH(32)) bus ();

    mdu_iter #(.WIDTH(32)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t        vecs[7];
    logic [64:0] exp_q[$];
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV division already truncates toward zero.
    function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: begin p = {32'b0, a} * {32'b0, b}; return {1'b0, p}; end
            2'd1: begin p = sa * sb; return {1'b0, p}; end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                if (op == 2'd2) return {1'b0, a % b, a / b};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Call off the clock edge; returns #1 after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.src1_i  = a;
        bus.src2_i  = b;
        exp_q.push_back(model(op, a, b));
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.op_i    = 2'($urandom);
        bus.src1_i  = $urandom;
        bus.src2_i  = $urandom;
        chk("busy_after_start", 64'(bus.busy_o), 64'd1);
        chk("dz_cleared_on_start", 64'(bus.div_zero_o), 64'd0);
        chk("hi_hold", 64'(bus.hi_o), 64'(last_hi));
        chk("lo_hold", 64'(bus.lo_o), 64'(last_lo));
    endtask

    task automatic wait_done(output int lat);
        logic [64:0] e;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done_o) break;
        end
        if (!bus.done_o) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: got no done_o within %0d cycles", lat);
            exp_q.delete();
            return;
        end
        if (exp_q.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
            return;
        end
        e = exp_q.pop_front();
        chk("sb_hi", 64'(bus.hi_o), 64'(e[63:32]));
        chk("sb_lo", 64'(bus.lo_o), 64'(e[31:0]));
        chk("sb_dz", 64'(bus.div_zero_o), 64'(e[64]));
        last_hi = e[63:32];
        last_lo = e[31:0];
    endtask

    int          lat;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    initial begin
        vecs[0] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1] = '{2'd1, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[2] = '{2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[3] = '{2'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[4] = '{2'd2, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0};
        vecs[5] = '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[6] = '{2'd2, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1};

        bus.start_i = 1'b0;
        bus.op_i    = '0;
        bus.src1_i  = '0;
        bus.src2_i  = '0;

        // Reset state
        #12;
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        chk("rst_done", 64'(bus.done_o), 64'd0);
        chk("rst_hi", 64'(bus.hi_o), 64'd0);
        chk("rst_lo", 64'(bus.lo_o), 64'd0);
        chk("rst_dz", 64'(bus.div_zero_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors with hand-derived results
        for (int i = 0; i < 7; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(lat);
            chk("vec_latency", 64'(lat), 64'd33);
            chk("vec_hi", 64'(bus.hi_o), 64'(vecs[i].hi));
            chk("vec_lo", 64'(bus.lo_o), 64'(vecs[i].lo));
            chk("vec_dz", 64'(bus.div_zero_o), 64'(vecs[i].dz));
            @(posedge clk);
            #1;
            chk("done_one_cycle", 64'(bus.done_o), 64'd0);
            chk("dz_hold", 64'(bus.div_zero_o), 64'(vecs[i].dz));
        end

        // Start ignored while busy, then back-to-back start in the done cycle
        issue(2'd0, 32'd5, 32'd6);
        repeat (9) @(posedge clk);
        #1;
        bus.start_i = 1'b1;
        bus.op_i    = 2'd2;
        bus.src1_i  = 32'd9;
        bus.src2_i  = 32'd3;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        wait_done(lat);
        chk("busy_start_latency", 64'(lat + 10), 64'd33);
        chk("ignored_lo", 64'(bus.lo_o), 64'd30);
        chk("ignored_hi", 64'(bus.hi_o), 64'd0);
        issue(2'd2, 32'd9, 32'd3);
        wait_done(lat);
        chk("b2b_latency", 64'(lat), 64'd33);
        chk("b2b_lo", 64'(bus.lo_o), 64'd3);
        chk("b2b_hi", 64'(bus.hi_o), 64'd0);

        // Reset mid-operation
        issue(2'd0, 32'd1234, 32'd5678);
        repeat (14) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(bus.busy_o), 64'd0);
        chk("abort_done", 64'(bus.done_o), 64'd0);
        chk("abort_hi", 64'(bus.hi_o), 64'd0);
        chk("abort_lo", 64'(bus.lo_o), 64'd0);
        exp_q.delete();
        last_hi = '0;
        last_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen = 0;
            repeat (40) begin
                @(posedge clk);
                #1;
                if (bus.done_o || bus.busy_o) seen++;
            end
            chk("no_done_after_abort", 64'(seen), 64'd0);
        end

        // Random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            issue(rop, ra, rb);
            wait_done(lat);
            chk("rand_latency", 64'(lat), 64'd33);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
